// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART transmit arbiter.
// FSM encoding, byte width and the default watchdog limit.
package uart_arb_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16384;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Transmitter-side handshake: start pulse and byte out, active/done back.
// The arbiter drives through master; the transmitter attaches as slave.
interface uart_tx_arbiter_if;
    import uart_arb_pkg::*;

    logic  o_Tx_DV;
    byte_t o_Tx_Byte;
    logic  i_Tx_Active;
    logic  i_Tx_Done;

    modport master (
        output o_Tx_DV,
        output o_Tx_Byte,
        input  i_Tx_Active,
        input  i_Tx_Done
    );

    modport slave (
        input  o_Tx_DV,
        input  o_Tx_Byte,
        output i_Tx_Active,
        output i_Tx_Done
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
// The pointer position itself is checked last, so the previous owner ranks lowest.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int k;
        o_win = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_win[k] = 1'b1;
                o_idx    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single 8N1 UART transmitter.
// Optional SEND watchdog enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]        i_Req_Last,
    output logic [NUM_REQ-1:0]        o_Req_Ack,
    output logic [NUM_REQ-1:0]        o_Grant,
    uart_tx_arbiter_if.master         tx,
    output logic                      o_Busy
`ifdef ARB_TIMEOUT_EN
    , output logic                    o_Timeout
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_owner;
    logic [IDX_W-1:0]               r_rr_ptr;
    logic                           r_last;
    logic [NUM_REQ-1:0][BYTE_W-1:0] w_bytes;
    logic [NUM_REQ-1:0]             w_win;
    logic [IDX_W-1:0]               w_idx;
    logic                           w_any;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 14) ? $clog2(TIMEOUT_CYCLES + 1) : 14;
    logic [CNT_W-1:0] r_cnt;
`endif

    assign w_bytes = i_Req_Byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req (i_Req),
        .i_ptr (r_rr_ptr),
        .o_win (w_win),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= IDX_W'(NUM_REQ - 1);
            r_last       <= 1'b0;
            o_Req_Ack    <= '0;
            o_Grant      <= '0;
            o_Busy       <= 1'b0;
            tx.o_Tx_DV   <= 1'b0;
            tx.o_Tx_Byte <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt        <= '0;
            o_Timeout    <= 1'b0;
`endif
        end else begin
            tx.o_Tx_DV <= 1'b0;
            o_Req_Ack  <= '0;
`ifdef ARB_TIMEOUT_EN
            o_Timeout  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        o_Grant <= w_win;
                        r_owner <= w_idx;
                        o_Busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!i_Req[r_owner]) begin
                        o_Grant  <= '0;
                        r_rr_ptr <= r_owner;
                        o_Busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (!tx.i_Tx_Active) begin
                        // Only start when the line is quiet: a byte left over from before reset must finish intact.
                        tx.o_Tx_Byte       <= w_bytes[r_owner];
                        tx.o_Tx_DV         <= 1'b1;
                        o_Req_Ack[r_owner] <= 1'b1;
                        r_last             <= i_Req_Last[r_owner];
                        r_state            <= SEND;
`ifdef ARB_TIMEOUT_EN
                        r_cnt              <= '0;
`endif
                    end
                end
                SEND: begin
                    if (tx.i_Tx_Done) begin
                        if (r_last) begin
                            o_Grant  <= '0;
                            r_rr_ptr <= r_owner;
                            o_Busy   <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= LOAD;
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_Timeout <= 1'b1;
                        o_Grant   <= '0;
                        r_rr_ptr  <= r_owner;
                        o_Busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    o_Grant <= '0;
                    o_Busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: producer queues, a transmitter model and a byte scoreboard.
// Timeout scenario is compiled only when ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int TXLEN = 4;

    typedef struct {
        int unsigned req;
        logic [7:0]  b;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_byte = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
`ifdef ARB_TIMEOUT_EN
    logic              tmo;
`endif

    uart_tx_arbiter_if tx ();

    uart_tx_arbiter #(
        .NUM_REQ (NREQ)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Req      (req),
        .i_Req_Byte (req_byte),
        .i_Req_Last (req_last),
        .o_Req_Ack  (ack),
        .o_Grant    (grant),
        .tx         (tx),
        .o_Busy     (busy)
`ifdef ARB_TIMEOUT_EN
        , .o_Timeout (tmo)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_dv = 0;
    int n_done = 0;

    exp_t       sb [$];
    logic [8:0] pq [NREQ][$];
    logic [NREQ-1:0] en = '1;
    logic force_active = 1'b0;
    logic tx_hang = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producers: retire the acked byte, then present the next one.
    always @(negedge clk) begin
        for (int k = 0; k < NREQ; k++)
            if (ack[k] && pq[k].size() > 0) void'(pq[k].pop_front());
        for (int k = 0; k < NREQ; k++) begin
            if (pq[k].size() > 0 && en[k]) begin
                req[k]            = 1'b1;
                req_byte[8*k +: 8] = pq[k][0][7:0];
                req_last[k]       = pq[k][0][8];
            end else begin
                req[k]      = 1'b0;
                req_last[k] = 1'b0;
            end
        end
    end

    // Transmitter model: TXLEN cycles active, then a one-cycle done.
    logic m_active = 1'b0;
    int   m_cnt = 0;
    initial begin
        tx.i_Tx_Active = 1'b0;
        tx.i_Tx_Done   = 1'b0;
    end
    always @(negedge clk) begin
        logic d;
        d = 1'b0;
        if (tx.o_Tx_DV) begin
            m_active = 1'b1;
            m_cnt    = TXLEN;
        end else if (m_active) begin
            if (m_cnt > 1) m_cnt--;
            else if (!tx_hang) begin
                m_active = 1'b0;
                d        = 1'b1;
                n_done++;
            end
        end
        tx.i_Tx_Active = m_active | force_active;
        tx.i_Tx_Done   = d;
    end

    // Scoreboard side: every DV must match the next expected byte and owner.
    logic prev_dv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (tx.o_Tx_DV) begin
            n_dv++;
            if (prev_dv) check("dv_width", 32'(prev_dv), 32'd0);
            if (sb.size() == 0) begin
                check("sb_unexpected_dv", 32'(tx.o_Tx_Byte), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("sb_byte", 32'(tx.o_Tx_Byte), 32'(e.b));
                check("sb_ack", 32'(ack), 32'(4'b0001 << e.req));
                check("sb_grant", 32'(grant), 32'(4'b0001 << e.req));
            end
        end
        prev_dv = tx.o_Tx_DV;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic last);
        exp_t e;
        pq[k].push_back({last, b});
        e.req = k;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        for (int k = 0; k < NREQ; k++) pq[k].delete();
        en  = '1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || busy) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) check({tag, "_idle_timeout"}, 32'(c), 32'(0));
    endtask

    task automatic wait_dv(input string tag, input int budget);
        int c;
        c = 0;
        while (!tx.o_Tx_DV && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) check({tag, "_dv_timeout"}, 32'(c), 32'(0));
    endtask

    initial begin
        int c;
        int dv0;
        int dn0;
        logic bad;

        // Reset state
        reset_dut();
        check("rst_grant", 32'(grant), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_dv", 32'(tx.o_Tx_DV), 0);
        check("rst_byte", 32'(tx.o_Tx_Byte), 0);
        check("rst_busy", 32'(busy), 0);

        // Single byte from requester 0: latency and pulse widths
        push(0, 8'h5A, 1'b1);
        tick();
        check("t1_grant_c0", 32'(grant), 0);
        tick();
        check("t1_grant_c1", 32'(grant), 32'b0001);
        check("t1_busy_c1", 32'(busy), 1);
        check("t1_dv_c1", 32'(tx.o_Tx_DV), 0);
        tick();
        check("t1_dv_c2", 32'(tx.o_Tx_DV), 1);
        check("t1_byte_c2", 32'(tx.o_Tx_Byte), 32'h5A);
        check("t1_ack_c2", 32'(ack), 32'b0001);
        tick();
        check("t1_dv_c3", 32'(tx.o_Tx_DV), 0);
        check("t1_ack_c3", 32'(ack), 0);
        wait_idle("t1", 40);
        check("t1_grant_end", 32'(grant), 0);
        check("t1_busy_end", 32'(busy), 0);

        // All four requesting single-byte packets: order 0,1,2,3,0,1
        reset_dut();
        dv0 = n_dv;
        dn0 = n_done;
        pq[0].push_back({1'b1, 8'hA0});
        pq[0].push_back({1'b1, 8'hA1});
        pq[1].push_back({1'b1, 8'hB0});
        pq[1].push_back({1'b1, 8'hB1});
        pq[2].push_back({1'b1, 8'hC0});
        pq[3].push_back({1'b1, 8'hD0});
        sb.push_back('{0, 8'hA0});
        sb.push_back('{1, 8'hB0});
        sb.push_back('{2, 8'hC0});
        sb.push_back('{3, 8'hD0});
        sb.push_back('{0, 8'hA1});
        sb.push_back('{1, 8'hB1});
        wait_idle("t2", 200);
        check("t2_dv_count", 32'(n_dv - dv0), 6);
        check("t2_done_count", 32'(n_done - dn0), 6);

        // Three-byte packet from 1 while 2 waits
        reset_dut();
        dn0 = n_done;
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        push(2, 8'h44, 1'b1);
        bad = 1'b0;
        c = 0;
        while ((sb.size() != 0 || busy) && c < 200) begin
            tick();
            c++;
            if (grant == 4'b0100 && (n_done - dn0) < 3) bad = 1'b1;
        end
        if (c >= 200) check("t3_idle_timeout", 32'(c), 0);
        check("t3_no_early_grant2", 32'(bad), 0);

        // Owner 2 abandons its packet after the first byte
        reset_dut();
        push(2, 8'h55, 1'b0);
        pq[2].push_back({1'b1, 8'h66});
        push(3, 8'h77, 1'b1);
        wait_dv("t4", 20);
        check("t4_first_grant", 32'(grant), 32'b0100);
        tick();
        en[2] = 1'b0;
        c = 0;
        while (grant == 4'b0100 && c < 40) begin
            tick();
            c++;
        end
        check("t4_grant_cleared", 32'(grant), 0);
        tick();
        check("t4_grant3", 32'(grant), 32'b1000);
        wait_idle("t4", 60);

        // Reset during SEND with the transmitter still busy
        reset_dut();
        push(0, 8'h99, 1'b1);
        wait_dv("t5", 20);
        tick();
        push(0, 8'h88, 1'b1);
        rst = 1'b1;
        force_active = 1'b1;
        tick();
        check("t5_rst_grant", 32'(grant), 0);
        check("t5_rst_ack", 32'(ack), 0);
        check("t5_rst_dv", 32'(tx.o_Tx_DV), 0);
        check("t5_rst_byte", 32'(tx.o_Tx_Byte), 0);
        check("t5_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        dv0 = n_dv;
        for (int i = 0; i < 50; i++) tick();
        check("t5_no_dv_while_active", 32'(n_dv - dv0), 0);
        check("t5_grant_hold", 32'(grant), 32'b0001);
        force_active = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t5_one_dv", 32'(n_dv - dv0), 1);
        wait_idle("t5", 40);

`ifdef ARB_TIMEOUT_EN
        // Transmitter never finishes: watchdog releases the owner
        reset_dut();
        tx_hang = 1'b1;
        push(0, 8'hA5, 1'b1);
        push(1, 8'hB6, 1'b1);
        wait_dv("t6", 20);
        c = 0;
        while (!tmo && c < 150) begin
            tick();
            c++;
        end
        check("t6_timeout_cycles", 32'(c), 100);
        check("t6_grant_cleared", 32'(grant), 0);
        tx_hang = 1'b0;
        tick();
        check("t6_timeout_pulse", 32'(tmo), 0);
        wait_idle("t6", 60);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
